// File: rtl/reg40_wr_arbiter_pkg.sv
// Shared definitions for the 40-word, 3-write-port register file write path.
//   NUM_WORDS    : number of addressable words in the register file
//   NUM_WR_PORTS : number of register-file write ports
//   ADDR_W       : word address width
//   addr_in_range(): 1 when an address selects an existing word
package reg40_wr_arbiter_pkg;

  localparam int unsigned NUM_WORDS    = 40;
  localparam int unsigned NUM_WR_PORTS = 3;
  localparam int unsigned ADDR_W       = 6;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(NUM_WORDS);
  endfunction

endpackage

// File: rtl/rr_rotate_4.sv
// Rotating-priority grant scan for up to 4 requesters.
// Ports:
//   rr_ptr       : highest-priority requester this cycle
//   valid        : per-requester request
//   oob          : per-requester address is outside the register file
//   addr_eq      : addr_eq[i][m] = requesters i and m carry the same address
//   ready        : per-requester accept (unrotated requester order)
//   port_en      : write port k receives a grant
//   port_sel     : requester index driving write port k
//   rr_ptr_next  : pointer value for the next cycle
module rr_rotate_4
  import reg40_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [1:0]              rr_ptr,
  input  logic [NUM_REQ-1:0]      valid,
  input  logic [NUM_REQ-1:0]      oob,
  input  logic [NUM_REQ-1:0]      addr_eq [NUM_REQ],
  output logic [NUM_REQ-1:0]      ready,
  output logic [NUM_WR_PORTS-1:0] port_en,
  output logic [1:0]              port_sel [NUM_WR_PORTS],
  output logic [1:0]              rr_ptr_next
);

  // idx[j] is the requester sitting at scan position j
  logic [1:0]         idx      [NUM_REQ];
  logic [NUM_REQ-1:0] rot_valid;
  logic [NUM_REQ-1:0] rot_oob;
  logic [NUM_REQ-1:0] rot_conf [NUM_REQ];

  always_comb begin
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      idx[j] = 2'((32'(rr_ptr) + j) % NUM_REQ);
    end
    rot_valid = '0;
    rot_oob   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      rot_valid[j] = valid[idx[j]];
      rot_oob[j]   = oob[idx[j]];
      rot_conf[j]  = '0;
      for (int unsigned m = 0; m < NUM_REQ; m++) begin
        rot_conf[j][m] = addr_eq[idx[j]][idx[m]];
      end
    end
  end

  logic [NUM_REQ-1:0] granted;
  logic [1:0]         cnt;
  logic [1:0]         last;
  logic               any_grant;

  // Out-of-range requests are accepted but never take a slot; an in-range
  // request is granted only if a port is free and no earlier grant in this
  // scan already targets the same word.
  always_comb begin
    ready     = '0;
    port_en   = '0;
    granted   = '0;
    cnt       = '0;
    last      = '0;
    any_grant = 1'b0;
    for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
      port_sel[k] = '0;
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (rot_valid[j]) begin
        if (rot_oob[j]) begin
          ready[idx[j]] = 1'b1;
        end else if ((cnt != 2'(NUM_WR_PORTS)) && !(|(rot_conf[j] & granted))) begin
          ready[idx[j]] = 1'b1;
          granted[j]    = 1'b1;
          for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
            if (cnt == 2'(k)) begin
              port_en[k]  = 1'b1;
              port_sel[k] = idx[j];
            end
          end
          cnt       = cnt + 2'd1;
          last      = idx[j];
          any_grant = 1'b1;
        end
      end
    end
    rr_ptr_next = rr_ptr;
    if (any_grant) begin
      rr_ptr_next = (last == 2'(NUM_REQ - 1)) ? 2'd0 : last + 2'd1;
    end
  end

endmodule

// File: rtl/reg40_wr_arbiter.sv
// Write arbiter in front of a 40-word register file with 3 write ports.
// Up to NUM_REQ requesters are scanned in rotating priority each cycle; up to
// 3 non-conflicting in-range requests are granted and registered onto the
// write ports one cycle later. Out-of-range addresses are accepted and
// dropped, raising err_oob for one cycle.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/addr/data/ready : per-requester valid/ready write channel
//   wrK_en/addr/data (K=0..2) : registered register-file write ports
//   err_oob                   : pulse after an out-of-range request is accepted
//   rr_ptr                    : current highest-priority requester (debug)
module reg40_wr_arbiter
  import reg40_wr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [WIDTH*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr0_en,
  output logic [ADDR_W-1:0]         wr0_addr,
  output logic [WIDTH-1:0]          wr0_data,
  output logic                      wr1_en,
  output logic [ADDR_W-1:0]         wr1_addr,
  output logic [WIDTH-1:0]          wr1_data,
  output logic                      wr2_en,
  output logic [ADDR_W-1:0]         wr2_addr,
  output logic [WIDTH-1:0]          wr2_data,
  output logic                      err_oob,
  output logic [1:0]                rr_ptr
);

  logic [ADDR_W-1:0]  addr    [NUM_REQ];
  logic [NUM_REQ-1:0] oob;
  logic [NUM_REQ-1:0] addr_eq [NUM_REQ];

  always_comb begin
    oob = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr[i] = req_addr[ADDR_W*i +: ADDR_W];
      oob[i]  = !addr_in_range(addr[i]);
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_eq[i] = '0;
      for (int unsigned m = 0; m < NUM_REQ; m++) begin
        addr_eq[i][m] = (addr[i] == addr[m]);
      end
    end
  end

  logic [NUM_REQ-1:0]      scan_ready;
  logic [NUM_WR_PORTS-1:0] port_en;
  logic [1:0]              port_sel [NUM_WR_PORTS];
  logic [1:0]              rr_ptr_next;

  rr_rotate_4 #(
    .NUM_REQ (NUM_REQ)
  ) u_scan (
    .rr_ptr      (rr_ptr),
    .valid       (req_valid),
    .oob         (oob),
    .addr_eq     (addr_eq),
    .ready       (scan_ready),
    .port_en     (port_en),
    .port_sel    (port_sel),
    .rr_ptr_next (rr_ptr_next)
  );

  assign req_ready = rst ? '0 : scan_ready;

  logic [ADDR_W-1:0] port_addr [NUM_WR_PORTS];
  logic [WIDTH-1:0]  port_data [NUM_WR_PORTS];
  logic              oob_hit;

  always_comb begin
    for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
      port_addr[k] = addr[port_sel[k]];
      port_data[k] = req_data[WIDTH*port_sel[k] +: WIDTH];
    end
    oob_hit = |(req_valid & oob & req_ready);
  end

  logic [NUM_WR_PORTS-1:0] wr_en_q;
  logic [ADDR_W-1:0]       wr_addr_q [NUM_WR_PORTS];
  logic [WIDTH-1:0]        wr_data_q [NUM_WR_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= '0;
      err_oob <= 1'b0;
      rr_ptr  <= '0;
      for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
        wr_addr_q[k] <= '0;
        wr_data_q[k] <= '0;
      end
    end else begin
      wr_en_q <= port_en;
      err_oob <= oob_hit;
      rr_ptr  <= rr_ptr_next;
      for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
        if (port_en[k]) begin
          wr_addr_q[k] <= port_addr[k];
          wr_data_q[k] <= port_data[k];
        end
      end
    end
  end

  assign wr0_en   = wr_en_q[0];
  assign wr1_en   = wr_en_q[1];
  assign wr2_en   = wr_en_q[2];
  assign wr0_addr = wr_addr_q[0];
  assign wr1_addr = wr_addr_q[1];
  assign wr2_addr = wr_addr_q[2];
  assign wr0_data = wr_data_q[0];
  assign wr1_data = wr_data_q[1];
  assign wr2_data = wr_data_q[2];

endmodule
